ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction prefetch engine for the alioth core: keeps up to MAX_OUTSTANDING single-beat AXI instruction reads in flight and buffers returned instructions in a FIFO_DEPTH-entry queue in front of the ID stage. Redirects (jump, branch prediction, trap) flush the queue and discard stale in-flight responses by count. It replaces the single-outstanding fetch path between the PC logic and `ifu_pipe`.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction/bus data width (one instruction per beat)
- ID_W, 4, AXI ID width (`BUS_ID_WIDTH`)
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered AR requests (≥1)
- FIFO_DEPTH, 4, instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- redirect_i  in  1  flush queue and restart fetch at redirect_addr_i
- redirect_addr_i  in  ADDR_W  new fetch address
- inst_o  out  DATA_W  head instruction
- inst_addr_o  out  ADDR_W  head instruction address
- inst_err_o  out  1  head entry returned RRESP≠OKAY
- inst_valid_o  out  1  head entry valid
- inst_ready_i  in  1  consumer pops head when valid&ready
- misaligned_o  out  1  fetch halted on non-4-byte-aligned redirect target
- M_AXI_AR*  out  ARID=0, ARADDR ADDR_W, ARLEN=0, ARSIZE=3'b010, ARBURST=2'b01, ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER=0, ARVALID 1; ARREADY in 1
- M_AXI_R*  in  RID ID_W, RDATA DATA_W, RRESP 2, RLAST 1, RUSER 4, RVALID 1; RREADY out 1

## Operation
- Reset: ARVALID=0, ARADDR=RESET_PC, fetch_pc=RESET_PC, RREADY=0 during reset and 1 afterwards, inst_valid_o=0, inst_o/inst_addr_o/inst_err_o=0, misaligned_o=0, outstanding=0, drop_cnt=0, state RUN.
- States: RUN (may raise ARVALID), AR_WAIT (ARVALID held, address stable until ARREADY), HALT (misaligned target; no issue).
- Credit: issue allowed when fifo_count + outstanding < FIFO_DEPTH and outstanding < MAX_OUTSTANDING; reserved space lets RREADY stay 1 permanently.
- RUN→AR_WAIT when credit: ARVALID=1, ARADDR=fetch_pc. AR_WAIT→RUN on ARREADY; fetch_pc += 4, outstanding += 1. Back-to-back issue permitted: AR handshake and new ARVALID in consecutive cycles.
- R beat (RVALID&RREADY): outstanding −= 1; if drop_cnt>0, drop_cnt −= 1 and beat discarded; else push {RDATA, address from in-order address queue, RRESP≠2'b00}.
- Redirect: FIFO emptied; pop ignored; R beat same cycle discarded; drop_cnt ← outstanding after this cycle's AR/R updates; fetch_pc ← redirect_addr_i. If ARVALID pending and not accepted, it stays asserted unchanged; on acceptance it increments drop_cnt too (stale flag). Redirect_addr[1:0]≠0 → HALT, misaligned_o=1 until next aligned redirect.
- Counters: outstanding and drop_cnt are $clog2(MAX_OUTSTANDING+1) bits; drop_cnt ≤ outstanding always.

## Timing
- Redirect in cycle N → ARVALID with new address in N+1 (N+1 after stale AR accepted if one pending).
- R beat in cycle N → inst_valid_o in N+1 (registered FIFO write).
- Simultaneous push and pop on full FIFO legal; count unchanged.
- Reset mid-transaction: all state cleared asynchronously; responses arriving after reset are dropped only if outstanding=0 (treated as protocol error, ignored).

## Configuration
- IFU_PREFETCH_BYPASS_EN defined: when FIFO empty and a non-dropped R beat arrives, it is presented on inst_* in the same cycle (combinational); if inst_ready_i=1 it is consumed without being written. Latency R→inst_valid_o = 0 cycles.
- Undefined: all beats pass through the FIFO; latency 1 cycle.

## Test plan
- Reset, ARREADY=1, memory latency 1, inst_ready_i=1 → AR addresses 0x8000_0000, 0x8000_0004, … back-to-back; inst_addr_o sequence matches, no gaps in steady state.
- inst_ready_i=0 for 20 cycles → exactly FIFO_DEPTH ARs issued, then ARVALID stays 0; FIFO holds 4 entries in order.
- Latency 5, 4 outstanding, redirect to 0x8000_0100 → next 4 R beats discarded, first inst_addr_o after redirect is 0x8000_0100.
- Redirect while ARVALID=1, ARREADY=0 → ARADDR unchanged until accepted; that response dropped; next AR is redirect target.
- RRESP=2'b10 on address 0x8000_0008 → entry emitted with inst_err_o=1, neighbours 0.
- Redirect to 0x8000_0102 → misaligned_o=1, no AR issued; redirect to 0x8000_0200 → misaligned_o=0, fetch resumes.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: multi-outstanding AXI instruction prefetcher with an in-order queue and redirect flush.
// Define IFU_PREFETCH_BYPASS_EN to present a response on inst_* in its arrival cycle when the queue is empty.
//   state   | meaning
//   RUN     | idle, raises ARVALID when credit allows
//   AR_WAIT | ARVALID held, ARADDR stable until ARREADY
//   HALT    | misaligned redirect target, no issue until an aligned redirect
module ifu_prefetch #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter int                ID_W            = 4,
    parameter int                MAX_OUTSTANDING = 4,
    parameter int                FIFO_DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_err_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              misaligned_o,
    output logic [ID_W-1:0]   M_AXI_ARID,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARLOCK,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic [2:0]        M_AXI_ARPROT,
    output logic [3:0]        M_AXI_ARQOS,
    output logic [3:0]        M_AXI_ARUSER,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [ID_W-1:0]   M_AXI_RID,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic [3:0]        M_AXI_RUSER,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int EW = DATA_W + ADDR_W + 1;

    typedef enum logic [1:0] {RUN, AR_WAIT, HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              misaligned_q, misaligned_d;
    logic              stale_q, stale_d;
    logic              rready_q, rready_d;
    logic [OW-1:0]     out_q, out_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [QW-1:0]     aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] aq_mem_q [MAX_OUTSTANDING];

    logic              ar_fire, r_take, r_drop, push;
    logic              fifo_wr, fifo_rd, head_valid, credit, can_decide;
    logic [EW-1:0]     beat_entry, head_entry;
    logic [ADDR_W-1:0] pc_base;
`ifdef IFU_PREFETCH_BYPASS_EN
    logic              bypass;
`endif

    logic unused_r;
    assign unused_r = ^{M_AXI_RID, M_AXI_RLAST, M_AXI_RUSER};

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARUSER  = 4'd0;
    assign M_AXI_ARVALID = (state_q == AR_WAIT);
    assign M_AXI_RREADY  = rready_q;
    assign misaligned_o  = misaligned_q;

    // Queue, response accounting and head presentation.
    always_comb begin
        rready_d   = 1'b1;
        ar_fire    = (state_q == AR_WAIT) & M_AXI_ARREADY;
        // A beat with nothing outstanding (e.g. left over from before reset) is ignored.
        r_take     = M_AXI_RVALID & rready_q & (out_q != '0);
        r_drop     = r_take & ((drop_q != '0) | redirect_i);
        push       = r_take & ~r_drop;
        beat_entry = {M_AXI_RDATA, aq_mem_q[aq_rd_q], (M_AXI_RRESP != 2'b00)};
        head_valid = (count_q != '0);
        head_entry = fifo_mem_q[rd_q];
        fifo_rd    = head_valid & inst_ready_i & ~redirect_i;
`ifdef IFU_PREFETCH_BYPASS_EN
        bypass       = push & ~head_valid;
        inst_valid_o = head_valid | bypass;
        fifo_wr      = push & ~(bypass & inst_ready_i);
        if (head_valid)
            {inst_o, inst_addr_o, inst_err_o} = head_entry;
        else if (bypass)
            {inst_o, inst_addr_o, inst_err_o} = beat_entry;
        else
            {inst_o, inst_addr_o, inst_err_o} = '0;
`else
        inst_valid_o = head_valid;
        fifo_wr      = push;
        {inst_o, inst_addr_o, inst_err_o} = head_valid ? head_entry : '0;
`endif

        out_d   = out_q + OW'(ar_fire) - OW'(r_take);
        count_d = count_q + CW'(fifo_wr) - CW'(fifo_rd);
        wr_d    = fifo_wr ? wr_q + 1'b1 : wr_q;
        rd_d    = fifo_rd ? rd_q + 1'b1 : rd_q;

        aq_wr_d = aq_wr_q;
        aq_rd_d = aq_rd_q;
        if (ar_fire)
            aq_wr_d = (aq_wr_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : aq_wr_q + 1'b1;
        if (r_take)
            aq_rd_d = (aq_rd_q == QW'(MAX_OUTSTANDING - 1)) ? '0 : aq_rd_q + 1'b1;

        drop_d  = drop_q;
        stale_d = stale_q & ~ar_fire;
        if (redirect_i) begin
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            drop_d  = out_d;
            // A request still waiting for ARREADY is not yet in out_d; remember to drop its beat later.
            stale_d = (state_q == AR_WAIT) & ~M_AXI_ARREADY;
        end else begin
            if (r_drop)
                drop_d = drop_d - 1'b1;
            if (ar_fire & stale_q)
                drop_d = drop_d + 1'b1;
        end
    end

    // Fetch FSM: decides the next request once any pending ARVALID has been accepted.
    always_comb begin
        state_d      = state_q;
        ar_addr_d    = ar_addr_q;
        pc_base      = redirect_i ? redirect_addr_i : fetch_pc_q;
        fetch_pc_d   = pc_base;
        misaligned_d = redirect_i ? (redirect_addr_i[1:0] != 2'b00) : misaligned_q;
        credit       = ((32'(count_d) + 32'(out_d)) < 32'(FIFO_DEPTH)) &&
                       (32'(out_d) < 32'(MAX_OUTSTANDING));
        can_decide   = (state_q != AR_WAIT) | M_AXI_ARREADY;
        if (can_decide) begin
            if (misaligned_d) begin
                state_d = HALT;
            end else if (credit) begin
                state_d    = AR_WAIT;
                ar_addr_d  = pc_base;
                fetch_pc_d = pc_base + ADDR_W'(4);
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ar_addr_q    <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            misaligned_q <= 1'b0;
            stale_q      <= 1'b0;
            rready_q     <= 1'b0;
            out_q        <= '0;
            drop_q       <= '0;
            count_q      <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            aq_wr_q      <= '0;
            aq_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            ar_addr_q    <= ar_addr_d;
            fetch_pc_q   <= fetch_pc_d;
            misaligned_q <= misaligned_d;
            stale_q      <= stale_d;
            rready_q     <= rready_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            aq_wr_q      <= aq_wr_d;
            aq_rd_q      <= aq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem_q[wr_q] <= beat_entry;
        if (ar_fire)
            aq_mem_q[aq_wr_q] <= ar_addr_q;
    end

endmodule
